// File: rtl/core_pipe_fetch_pkg.sv
// Shared widths, bus FSM states and the instruction-length helper
// for the fetch stage and its halfword buffer.
package core_pipe_fetch_pkg;

    localparam int XL          = 63;
    localparam int FD_IBUF_R   = 31;
    localparam int FD_ERR_R    = 1;
    localparam int FETCH_BUS_W = 64;
    localparam int HW_W        = 16;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2
    } bus_state_t;

    // Low two opcode bits of 2'b11 mark a 32-bit encoding.
    function automatic logic is_32bit(input logic [1:0] lo);
        return lo == 2'b11;
    endfunction

endpackage

// File: rtl/core_pipe_fetch_buffer.sv
// Halfword shift buffer with per-halfword error tags: pops 0/1/2 from the head
// and appends a fetched 64-bit word starting at a given halfword index.
module core_fetch_buffer
    import core_pipe_fetch_pkg::*;
#(
    parameter int BUF_HW = 8,
    parameter int CNT_W  = $clog2(BUF_HW + 1)
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   flush,
    input  logic                   push,
    input  logic [FETCH_BUS_W-1:0] push_data,
    input  logic                   push_err,
    input  logic [1:0]             push_start,
    input  logic [1:0]             pop,
    output logic [HW_W-1:0]        hw0,
    output logic [HW_W-1:0]        hw1,
    output logic                   err0,
    output logic                   err1,
    output logic [CNT_W-1:0]       count,
    output logic [CNT_W-1:0]       count_next
);

    localparam int IDX_W = $clog2(BUF_HW);

    logic [HW_W-1:0]  data_reg  [BUF_HW];
    logic             err_reg   [BUF_HW];
    logic [HW_W-1:0]  data_next [BUF_HW];
    logic             err_next  [BUF_HW];
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] kept;
    logic [2:0]       push_n;
    int               slot;

    always_comb begin
        kept   = count_reg - CNT_W'(pop);
        push_n = push ? (3'd4 - {1'b0, push_start}) : 3'd0;
        slot   = 0;
        for (int i = 0; i < BUF_HW; i++) begin
            data_next[i] = '0;
            err_next[i]  = 1'b0;
            if (i + int'(pop) < BUF_HW) begin
                data_next[i] = data_reg[IDX_W'(i + int'(pop))];
                err_next[i]  = err_reg[IDX_W'(i + int'(pop))];
            end
        end
        // Appended halfwords land right behind whatever survives the pop.
        for (int k = 0; k < 4; k++) begin
            if (push && k >= int'(push_start)) begin
                slot = int'(kept) + k - int'(push_start);
                if (slot < BUF_HW) begin
                    data_next[IDX_W'(slot)] = push_data[HW_W*k +: HW_W];
                    err_next[IDX_W'(slot)]  = push_err;
                end
            end
        end
        count_next = flush ? '0 : kept + CNT_W'(push_n);
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            count_reg <= '0;
            for (int i = 0; i < BUF_HW; i++) begin
                data_reg[i] <= '0;
                err_reg[i]  <= 1'b0;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < BUF_HW; i++) begin
                data_reg[i] <= data_next[i];
                err_reg[i]  <= err_next[i];
            end
        end
    end

    assign hw0   = data_reg[0];
    assign hw1   = data_reg[1];
    assign err0  = err_reg[0];
    assign err1  = err_reg[1];
    assign count = count_reg;

endmodule

// File: rtl/core_pipe_fetch.sv
// Fetch stage: issues aligned 64-bit reads, buffers halfwords and presents one
// 16/32-bit instruction per cycle to decode; handles control-flow redirects.
module core_pipe_fetch
    import core_pipe_fetch_pkg::*;
#(
    parameter logic [XL:0] PC_RESET = 64'h0000_0000_8000_0000,
    parameter int          BUF_HW   = 8
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    output logic                   imem_req,
    input  logic                   imem_gnt,
    output logic [XL:0]            imem_addr,
    input  logic                   imem_recv,
    output logic                   imem_ack,
    input  logic [FETCH_BUS_W-1:0] imem_rdata,
    input  logic                   imem_error,
    output logic                   s1_16bit,
    output logic                   s1_32bit,
    output logic [FD_IBUF_R:0]     s1_instr,
    output logic [XL:0]            s1_pc,
    output logic [XL:0]            s1_npc,
    output logic [FD_ERR_R:0]      s1_ferr,
    input  logic                   s2_eat_2,
    input  logic                   s2_eat_4,
    input  logic                   cf_valid,
    input  logic [XL:0]            cf_target,
    output logic                   cf_ack
);

    localparam int CNT_W = $clog2(BUF_HW + 1);
    localparam int W     = XL + 1;
    localparam logic [CNT_W-1:0] ROOM_MAX = CNT_W'(BUF_HW - 4);

    bus_state_t       state_reg;
    logic             drop_reg;
    logic [XL:0]      fetch_addr_reg;
    logic [1:0]       skip_reg;
    logic [XL:0]      pc_reg;

    logic [HW_W-1:0]  hw0, hw1;
    logic             err0, err1;
    logic [CNT_W-1:0] count, count_next;
    logic             v16, v32, push, room;
    logic [1:0]       pop;
    logic [2:0]       npc_inc;

    core_fetch_buffer #(
        .BUF_HW (BUF_HW),
        .CNT_W  (CNT_W)
    ) u_buf (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (cf_ack),
        .push       (push),
        .push_data  (imem_rdata),
        .push_err   (imem_error),
        .push_start (skip_reg),
        .pop        (pop),
        .hw0        (hw0),
        .hw1        (hw1),
        .err0       (err0),
        .err1       (err1),
        .count      (count),
        .count_next (count_next)
    );

    assign imem_req  = (state_reg == BUS_REQ);
    assign imem_addr = imem_req ? fetch_addr_reg : '0;
    assign imem_ack  = 1'b1;
    assign cf_ack    = cf_valid && !(imem_req && !imem_gnt);

    // An errored head is shown as 16-bit so decode can raise the fault
    // without waiting for a second halfword that may never arrive.
    assign v16 = (count != '0) && (!is_32bit(hw0[1:0]) || err0);
    assign v32 = (count >= CNT_W'(2)) && is_32bit(hw0[1:0]) && !err0;

    assign s1_16bit = v16;
    assign s1_32bit = v32;
    assign s1_instr = v32 ? {hw1, hw0} : (v16 ? {16'b0, hw0} : '0);
    assign s1_ferr  = {v32 && err1, (v16 || v32) && err0};
    assign npc_inc  = v32 ? 3'd4 : (v16 ? 3'd2 : 3'd0);
    assign s1_pc    = pc_reg;
    assign s1_npc   = pc_reg + W'(npc_inc);

    assign pop  = cf_ack ? 2'd0 :
                  (s2_eat_2 && !s2_eat_4 && v16) ? 2'd1 :
                  (s2_eat_4 && !s2_eat_2 && v32) ? 2'd2 : 2'd0;
    assign push = (state_reg == BUS_WAIT) && imem_recv && !drop_reg && !cf_ack;
    assign room = (count_next <= ROOM_MAX);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_reg      <= BUS_IDLE;
            drop_reg       <= 1'b0;
            fetch_addr_reg <= PC_RESET & ~W'(7);
            skip_reg       <= PC_RESET[2:1];
            pc_reg         <= PC_RESET & ~W'(1);
        end else begin
            case (state_reg)
                BUS_IDLE: begin
                    if (room) state_reg <= BUS_REQ;
                end
                BUS_REQ: begin
                    if (imem_gnt) begin
                        state_reg      <= BUS_WAIT;
                        fetch_addr_reg <= fetch_addr_reg + W'(8);
                    end
                end
                BUS_WAIT: begin
                    if (imem_recv) begin
                        state_reg <= room ? BUS_REQ : BUS_IDLE;
                        drop_reg  <= 1'b0;
                    end
                end
                default: state_reg <= BUS_IDLE;
            endcase

            if (push) skip_reg <= 2'd0;

            if (pop == 2'd1)      pc_reg <= pc_reg + W'(2);
            else if (pop == 2'd2) pc_reg <= pc_reg + W'(4);

            // Redirect wins: later assignments override the above.
            if (cf_ack) begin
                pc_reg         <= cf_target & ~W'(1);
                fetch_addr_reg <= cf_target & ~W'(7);
                skip_reg       <= cf_target[2:1];
                drop_reg       <= (state_reg == BUS_REQ) ||
                                  ((state_reg == BUS_WAIT) && !imem_recv);
            end
        end
    end

endmodule

// File: tb/tb_core_pipe_fetch.sv
// Directed bench for core_pipe_fetch: queue-based reference model compared on
// every falling edge, plus hand-computed literal checks on key transactions.
module tb_core_pipe_fetch;

    localparam int BUF_HW = 8;
    localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        imem_req, imem_gnt = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_recv = 1'b0, imem_ack;
    logic [63:0] imem_rdata = '0;
    logic        imem_error = 1'b0;
    logic        s1_16bit, s1_32bit;
    logic [31:0] s1_instr;
    logic [63:0] s1_pc, s1_npc;
    logic [1:0]  s1_ferr;
    logic        s2_eat_2 = 1'b0, s2_eat_4 = 1'b0;
    logic        cf_valid = 1'b0;
    logic [63:0] cf_target = '0;
    logic        cf_ack;

    int vectors = 0;
    int miscompares = 0;

    core_pipe_fetch #(.PC_RESET(PC_RST), .BUF_HW(BUF_HW)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
        .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .imem_error(imem_error),
        .s1_16bit(s1_16bit), .s1_32bit(s1_32bit), .s1_instr(s1_instr),
        .s1_pc(s1_pc), .s1_npc(s1_npc), .s1_ferr(s1_ferr),
        .s2_eat_2(s2_eat_2), .s2_eat_4(s2_eat_4),
        .cf_valid(cf_valid), .cf_target(cf_target), .cf_ack(cf_ack)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: halfword queue entries are {err, data}.
    logic [16:0] mq[$];
    logic [63:0] m_pc, m_faddr;
    logic [1:0]  m_skip;
    bit          m_out, m_drop, m_started;

    always @(negedge g_clk) begin
        if (!g_resetn) begin
            mq.delete();
            m_pc = PC_RST & ~64'd1;
            m_faddr = PC_RST & ~64'd7;
            m_skip = PC_RST[2:1];
            m_out = 0; m_drop = 0; m_started = 0;
            chk("rst imem_req", imem_req, 0);
            chk("rst imem_addr", imem_addr, 0);
            chk("rst imem_ack", imem_ack, 1);
            chk("rst s1_16bit", s1_16bit, 0);
            chk("rst s1_32bit", s1_32bit, 0);
            chk("rst s1_instr", s1_instr, 0);
            chk("rst s1_pc", s1_pc, PC_RST);
            chk("rst s1_npc", s1_npc, PC_RST);
            chk("rst s1_ferr", s1_ferr, 0);
            chk("rst cf_ack", cf_ack, 0);
        end else begin
            bit m_req, m_ack, v16, v32, still;
            logic [31:0] e_instr;
            logic [1:0]  e_ferr;
            logic [63:0] e_npc;
            int n;
            n = mq.size();
            m_req = m_started && !m_out && (n <= BUF_HW - 4);
            m_ack = cf_valid && !(m_req && !imem_gnt);
            v16 = (n >= 1) && (mq[0][1:0] != 2'b11 || mq[0][16]);
            v32 = (n >= 2) && (mq[0][1:0] == 2'b11) && !mq[0][16];
            e_instr = v32 ? {mq[1][15:0], mq[0][15:0]} : (v16 ? {16'h0, mq[0][15:0]} : 32'h0);
            e_ferr = {v32 && mq[1][16], (v16 || v32) && mq[0][16]};
            e_npc = m_pc + (v32 ? 64'd4 : (v16 ? 64'd2 : 64'd0));
            chk("imem_req", imem_req, m_req);
            chk("imem_addr", imem_addr, m_req ? m_faddr : 64'd0);
            chk("cf_ack", cf_ack, m_ack);
            chk("s1_16bit", s1_16bit, v16);
            chk("s1_32bit", s1_32bit, v32);
            chk("s1_instr", s1_instr, e_instr);
            chk("s1_pc", s1_pc, m_pc);
            chk("s1_npc", s1_npc, e_npc);
            chk("s1_ferr", s1_ferr, e_ferr);
            if (s2_eat_2 || s2_eat_4)
                chk("legal eat", (s2_eat_2 && v16 && !s2_eat_4) || (s2_eat_4 && v32 && !s2_eat_2), 1);

            if (m_ack) begin
                still = (m_req && imem_gnt) || (m_out && !imem_recv);
                mq.delete();
                m_pc = cf_target & ~64'd1;
                m_faddr = cf_target & ~64'd7;
                m_skip = cf_target[2:1];
                m_out = still;
                m_drop = still;
            end else begin
                if (s2_eat_2 && v16 && !s2_eat_4) begin
                    void'(mq.pop_front()); m_pc += 2;
                end else if (s2_eat_4 && v32 && !s2_eat_2) begin
                    void'(mq.pop_front()); void'(mq.pop_front()); m_pc += 4;
                end
                if (imem_recv && m_out) begin
                    m_out = 0;
                    if (m_drop) m_drop = 0;
                    else begin
                        for (int k = int'(m_skip); k < 4; k++)
                            mq.push_back({imem_error, imem_rdata[16*k +: 16]});
                        m_skip = 0;
                    end
                end
                if (m_req && imem_gnt) begin
                    m_out = 1; m_faddr += 8;
                end
            end
            m_started = 1;
        end
    end

    task automatic tick();
        @(posedge g_clk); #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40 && !imem_req; i++) tick();
        chk("req wait", imem_req, 1);
    endtask

    task automatic grant();
        imem_gnt = 1; tick(); imem_gnt = 0;
    endtask

    task automatic respond(input logic [63:0] d, input logic e);
        imem_rdata = d; imem_error = e; imem_recv = 1;
        tick();
        imem_recv = 0; imem_error = 0;
    endtask

    task automatic fetch(input logic [63:0] d, input logic e);
        wait_req(); grant(); respond(d, e);
    endtask

    task automatic eat2();
        for (int i = 0; i < 40 && !s1_16bit; i++) tick();
        chk("eat2 wait", s1_16bit, 1);
        s2_eat_2 = 1; tick(); s2_eat_2 = 0;
    endtask

    task automatic eat4();
        for (int i = 0; i < 40 && !s1_32bit; i++) tick();
        chk("eat4 wait", s1_32bit, 1);
        s2_eat_4 = 1; tick(); s2_eat_4 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        g_resetn = 1;
        tick();
        $display("reset release: req=%0b addr=%h", imem_req, imem_addr);
        chk("first req", imem_req, 1);
        chk("first addr", imem_addr, 64'h8000_0000);

        grant(); respond(64'h00000013_00a00513, 0);
        $display("resp0: instr=%h pc=%h npc=%h", s1_instr, s1_pc, s1_npc);
        chk("r0 32bit", s1_32bit, 1);
        chk("r0 instr", s1_instr, 32'h00a00513);
        chk("r0 pc", s1_pc, 64'h8000_0000);
        chk("r0 npc", s1_npc, 64'h8000_0004);
        eat4();
        chk("r0b instr", s1_instr, 32'h00000013);
        chk("r0b pc", s1_pc, 64'h8000_0004);
        eat4();

        fetch(64'h0000_0013_0001_4501, 0);
        $display("mixed: instr=%h pc=%h", s1_instr, s1_pc);
        chk("mx0 16bit", s1_16bit, 1);
        chk("mx0 instr", s1_instr, 32'h4501);
        chk("mx0 pc", s1_pc, 64'h8000_0008);
        eat2();
        chk("mx1 instr", s1_instr, 32'h0001);
        chk("mx1 pc", s1_pc, 64'h8000_000a);
        eat2();
        chk("mx2 32bit", s1_32bit, 1);
        chk("mx2 instr", s1_instr, 32'h00000013);
        chk("mx2 pc", s1_pc, 64'h8000_000c);
        eat4();

        fetch(64'h0513_0001_0001_0001, 0);
        eat2(); eat2(); eat2();
        $display("straddle half: 16=%0b 32=%0b pc=%h", s1_16bit, s1_32bit, s1_pc);
        chk("st wait 32bit", s1_32bit, 0);
        chk("st wait 16bit", s1_16bit, 0);
        fetch(64'h0001_0001_0001_00a0, 0);
        $display("straddle: instr=%h pc=%h", s1_instr, s1_pc);
        chk("st 32bit", s1_32bit, 1);
        chk("st instr", s1_instr, 32'h00a00513);
        chk("st pc", s1_pc, 64'h8000_0016);
        eat4(); eat2(); eat2(); eat2();

        wait_req(); grant();
        cf_valid = 1; cf_target = 64'h8000_0102; #1;
        $display("redirect in flight: cf_ack=%0b", cf_ack);
        chk("rd ack", cf_ack, 1);
        tick(); cf_valid = 0;
        respond(64'hffff_ffff_ffff_ffff, 0);
        chk("rd dropped", s1_16bit | s1_32bit, 0);
        wait_req();
        chk("rd addr", imem_addr, 64'h8000_0100);
        grant(); respond(64'h0001_0001_4501_dead, 0);
        $display("redirect target: instr=%h pc=%h", s1_instr, s1_pc);
        chk("rd instr", s1_instr, 32'h4501);
        chk("rd pc", s1_pc, 64'h8000_0102);
        eat2(); eat2(); eat2();

        wait_req();
        cf_valid = 1; cf_target = 64'h8000_0200; #1;
        chk("hold ack0", cf_ack, 0);
        chk("hold addr0", imem_addr, 64'h8000_0108);
        tick();
        chk("hold ack1", cf_ack, 0);
        chk("hold addr1", imem_addr, 64'h8000_0108);
        imem_gnt = 1; #1;
        $display("redirect on grant: cf_ack=%0b", cf_ack);
        chk("hold ack gnt", cf_ack, 1);
        tick(); imem_gnt = 0; cf_valid = 0;
        respond(64'h0000_0000_0000_0013, 0);
        chk("hold dropped", s1_16bit | s1_32bit, 0);
        wait_req();
        chk("hold new addr", imem_addr, 64'h8000_0200);
        grant(); respond(64'h0001_0001_0001_0001, 0);
        chk("hold pc", s1_pc, 64'h8000_0200);
        eat2(); eat2(); eat2(); eat2();

        fetch(64'h0001_0001_0001_0003, 1);
        $display("bus error: 16=%0b ferr=%b instr=%h", s1_16bit, s1_ferr, s1_instr);
        chk("err 16bit", s1_16bit, 1);
        chk("err 32bit", s1_32bit, 0);
        chk("err ferr", s1_ferr, 2'b01);
        chk("err instr", s1_instr, 32'h0003);
        eat2(); eat2(); eat2(); eat2();

        wait_req(); grant();
        g_resetn = 0; #1;
        $display("async reset: req=%0b pc=%h", imem_req, s1_pc);
        chk("ar req", imem_req, 0);
        chk("ar pc", s1_pc, PC_RST);
        chk("ar 16bit", s1_16bit, 0);
        tick(); tick();
        g_resetn = 1;
        imem_rdata = 64'h0001_0001_0001_0001; imem_recv = 1;
        tick(); imem_recv = 0;
        chk("stale resp", s1_16bit | s1_32bit, 0);
        wait_req();
        chk("ar addr", imem_addr, 64'h8000_0000);
        grant(); respond(64'h00000013_00a00513, 0);
        chk("ar instr", s1_instr, 32'h00a00513);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_pipe_fetch.md
Name: core_pipe_fetch

Overview:
- Pipeline fetch stage and instruction buffer.
- Issues 64-bit aligned reads on the instruction memory bus and buffers the returned halfwords.
- Presents one 16- or 32-bit instruction per cycle to the decode stage, using the s1_* / s2_eat_* handshake.
- Accepts control flow redirects (cf_valid/cf_target) and acknowledges them with cf_ack.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC after reset; bit 0 is ignored.
- BUF_HW, 8, instruction buffer depth in halfwords. Must be at least 8.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  reset; one clock, asynchronous, active-low
- imem_req  out  1  fetch request valid
- imem_gnt  in  1  request accepted this cycle
- imem_addr  out  64  fetch address; bits [2:0] are always 0
- imem_recv  in  1  response valid
- imem_ack  out  1  response accepted; tied to 1
- imem_rdata  in  64  response data, little-endian halfwords
- imem_error  in  1  response bus error
- s1_16bit  out  1  valid 16-bit instruction presented
- s1_32bit  out  1  valid 32-bit instruction presented
- s1_instr  out  32  instruction; bits [31:16] are zero when 16-bit
- s1_pc  out  64  PC of the presented instruction
- s1_npc  out  64  s1_pc+2 if 16-bit, s1_pc+4 if 32-bit, otherwise s1_pc
- s1_ferr  out  2  per-halfword fetch error, {hw1,hw0}
- s2_eat_2  in  1  decode consumes 2 bytes
- s2_eat_4  in  1  decode consumes 4 bytes
- cf_valid  in  1  redirect request
- cf_target  in  64  redirect destination
- cf_ack  out  1  redirect accepted this cycle

Behaviour:
- Reset (async, g_resetn=0):
  - Buffer empty; outstanding=0; drop=0.
  - s1_pc=PC_RESET; fetch_addr=PC_RESET&~7; skip=PC_RESET[2:1].
  - All outputs 0 except s1_pc, s1_npc (=PC_RESET) and imem_ack.
- Request issue:
  - imem_req=1 when outstanding=0 and occupancy<=BUF_HW-4.
  - Once raised, imem_req and imem_addr hold stable until imem_gnt.
  - On grant: outstanding=1; fetch_addr+=8, wrapping modulo 2^64.
- Response (imem_recv while outstanding=1):
  - outstanding=0.
  - If drop=1: discard the data and clear drop.
  - Otherwise append halfwords skip..3 in ascending order, each tagged with imem_error, then set skip=0.
  - imem_recv while outstanding=0 is ignored; this covers a response arriving after a mid-transaction reset.
- Length and presentation, with hw0 as the buffer head:
  - s1_16bit=1 if occupancy>=1 and (hw0[1:0]!=2'b11 or hw0 has its error tag).
  - s1_32bit=1 if occupancy>=2, hw0[1:0]==2'b11 and hw0 has no error tag.
  - Neither set otherwise, e.g. a 32-bit instruction with only one halfword present waits.
  - s1_instr={hw1,hw0} when 32-bit, {16'b0,hw0} when 16-bit, 0 when invalid.
  - s1_ferr={err1 when 32-bit else 0, err0}.
  - All presentation outputs are combinational from registered state.
- Consume:
  - s2_eat_2 while s1_16bit: shift out 1 halfword, s1_pc+=2.
  - s2_eat_4 while s1_32bit: shift out 2 halfwords, s1_pc+=4.
  - An eat without the matching valid, or both eats together, is illegal. It is ignored, and the bench asserts that it never occurs.
  - Append and shift in the same cycle are both applied: occupancy' = occupancy + appended − eaten.
- Redirect:
  - cf_ack = cf_valid && !(imem_req && !imem_gnt). It is combinational; the ack is held off while an ungranted request is pending.
  - On cf_ack:
    - Buffer flushed.
    - s1_pc = cf_target with bit 0 cleared; fetch_addr = target&~7; skip = target[2:1].
    - drop=1 if a response is still outstanding after this cycle (granted this cycle or earlier and not yet received).
    - A response received in the ack cycle is discarded.
    - Eats in the ack cycle are ignored.
  - Redirect takes priority over append and consume.
- Occupancy never exceeds BUF_HW; the request rule guarantees room for 4 halfwords.

Decomposition:
- core_common.vh: XL=63, FD_IBUF_R=31, FD_ERR_R=1, REG/width constants; add FETCH_BUS_W=64.
- Sub-module core_fetch_buffer: halfword shift buffer with data and error tags.
  - Inputs: append (data, error, start index) and pop count 0/1/2.
  - Output: occupancy.
- core_pipe_fetch holds the PC, bus FSM (IDLE/REQ/WAIT), drop flag and length decode.

Test Plan:
- Reset, PC_RESET=0x80000000:
  - imem_req=1, imem_addr=0x80000000 in the first cycle after reset release.
  - Respond with 64'h00000013_00a00513 → s1_32bit, instr 0x00a00513, pc 0x80000000, npc 0x80000004.
  - eat_4 → instr 0x00000013, pc 0x80000004.
- Mixed width: rdata 64'h0000_0013_0001_4501 → 16-bit 0x4501 @+0, then 16-bit 0x0001 @+2, then 32-bit 0x00000013 @+4.
- Straddle:
  - First response 64'h0513_0001_0001_0001 → after three eat_2, s1_32bit=0 with occupancy 1.
  - Second response hw0=0x00a0 → s1_32bit, instr 0x00a00513, pc base+6.
- Redirect with a response in flight: cf_valid, target 0x80000102 → cf_ack=1.
  - The old response is dropped.
  - Next request addr 0x80000100.
  - The first instruction is taken from hw1, with pc 0x80000102.
- Redirect while imem_req=1, imem_gnt=0:
  - cf_ack stays 0 and imem_addr is stable.
  - In the cycle imem_gnt=1, cf_ack=1, and the granted response is later dropped.
- Bus error: response with imem_error=1 → s1_16bit=1, s1_ferr=2'b01 regardless of hw0[1:0]. Asserting g_resetn=0 mid-wait clears all state asynchronously.
